// File: rtl/counter_sched_pkg.sv
// Shared op encodings, FSM state type and arbitration helper for counter_sched.
// Pure declarations: no latency, no flow control.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_INC = 2'b01,
        OP_DEC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    // A lone requester always wins; a tie goes to whoever rr_ptr names.
    function automatic logic pick_winner(input logic [1:0] req, input logic rr_ptr);
        logic win;
        case (req)
            2'b10:   win = 1'b1;
            2'b11:   win = rr_ptr;
            default: win = 1'b0;
        endcase
        return win;
    endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Request/op/grant bundle plus counter status between two requesters and counter_sched.
// Combinational wires only; req is held by a requester until its gnt pulse.
interface counter_sched_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [1:0]       gnt;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
    logic             err;

    modport master (
        output req, op0, op1,
        input  gnt, count, at_max, at_zero, err
    );

    modport slave (
        input  req, op0, op1,
        output gnt, count, at_max, at_zero, err
    );
endinterface

// File: rtl/counter_sched_sat_counter.sv
// Saturating 0..LIMIT counter applying one op when en is high; result visible next cycle.
// No backpressure: an illegal INC/DEC holds the count and sets the sticky err flag.
module sat_counter
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LIMIT = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  op_t              op,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             err
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            err   <= 1'b0;
        end else if (en) begin
            case (op)
                OP_INC: begin
                    if (count < LIM) count <= count + ONE;
                    else             err   <= 1'b1;
                end
                OP_DEC: begin
                    if (count != '0) count <= count - ONE;
                    else             err   <= 1'b1;
                end
                OP_CLR:  count <= '0;
                default: count <= count;
            endcase
        end
    end

    assign at_max  = (count == LIM);
    assign at_zero = (count == '0);

    always @(posedge clk) begin
        if (!rst) assert (count <= LIM);
    end

endmodule

// File: rtl/counter_sched.sv
// Two-requester round-robin scheduler for a shared saturating counter; gnt one cycle after req, count one cycle later.
// At most one op per two cycles; a requester holds req until its grant pulse.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LIMIT = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_sched_if.slave       bus
);

    if (longint'(LIMIT) >= (longint'(1) << WIDTH)) begin : g_bad_limit
        $error("counter_sched: LIMIT must be below 2**WIDTH");
    end
    if ($bits(bus.count) != WIDTH) begin : g_bad_if_width
        $error("counter_sched: interface WIDTH differs from module WIDTH");
    end

    state_t state;
    state_t state_nxt;
    logic   winner;
    logic   winner_nxt;
    logic   rr_ptr;
    op_t    lat_op;
    op_t    lat_op_nxt;
    logic   exec_en;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.req != 2'b00) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs depend on registered state/winner only, never on live inputs.
    always_comb begin
        bus.gnt = 2'b00;
        exec_en = 1'b0;
        if (state == S_EXEC) begin
            exec_en = 1'b1;
            bus.gnt = winner ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        winner_nxt = pick_winner(bus.req, rr_ptr);
        lat_op_nxt = winner_nxt ? op_t'(bus.op1) : op_t'(bus.op0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            winner <= 1'b0;
            lat_op <= OP_NOP;
            rr_ptr <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.req != 2'b00) begin
                winner <= winner_nxt;
                lat_op <= lat_op_nxt;
            end
            if (state == S_EXEC) rr_ptr <= ~winner;
        end
    end

    sat_counter #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (exec_en),
        .op      (lat_op),
        .count   (bus.count),
        .at_max  (bus.at_max),
        .at_zero (bus.at_zero),
        .err     (bus.err)
    );

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus randomized traffic against a queue-based model.
module tb_counter_sched;

    localparam int WIDTH = 8;
    localparam int LIMIT = 9;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    counter_sched_if #(.WIDTH(WIDTH)) bus();

    counter_sched #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a granted job waits one cycle in a queue, then its op is applied.
    typedef struct packed {
        logic       who;
        logic [1:0] op;
    } job_t;

    job_t       pend[$];
    job_t       mj;
    int         m_count;
    bit         m_err;
    bit         m_tie;
    logic [1:0] m_gnt;

    always @(posedge clk) begin
        if (rst) begin
            m_count = 0;
            m_err   = 1'b0;
            m_tie   = 1'b0;
            m_gnt   = 2'b00;
            pend.delete();
        end else if (pend.size() != 0) begin
            mj = pend.pop_front();
            case (mj.op)
                2'b01: if (m_count < LIMIT) m_count = m_count + 1; else m_err = 1'b1;
                2'b10: if (m_count > 0) m_count = m_count - 1; else m_err = 1'b1;
                2'b11: m_count = 0;
                default: ;
            endcase
            m_tie = !mj.who;
            m_gnt = 2'b00;
        end else if (bus.req != 2'b00) begin
            mj.who = (bus.req == 2'b11) ? m_tie : bus.req[1];
            mj.op  = mj.who ? bus.op1 : bus.op0;
            pend.push_back(mj);
            m_gnt = mj.who ? 2'b10 : 2'b01;
        end else begin
            m_gnt = 2'b00;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 2'b00;
        bus.op0 = 2'b00;
        bus.op1 = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [1:0] rand_op();
        int r;
        r = int'($urandom % 8);
        if (r < 4)      return 2'b01;
        else if (r < 6) return 2'b10;
        else if (r < 7) return 2'b11;
        else            return 2'b00;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", bus.gnt); end
        checks++; if (bus.count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.at_zero !== 1'b1) begin failures++; $display("FAIL reset_at_zero got=%b exp=1", bus.at_zero); end
        checks++; if (bus.at_max !== 1'b0) begin failures++; $display("FAIL reset_at_max got=%b exp=0", bus.at_max); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_single_inc();
        do_reset();
        bus.req = 2'b01; bus.op0 = 2'b01;
        tick();
        checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL single_gnt1 got=%b exp=01", bus.gnt); end
        checks++; if (bus.count !== 8'd0) begin failures++; $display("FAIL single_count_early got=%0d exp=0", bus.count); end
        tick();
        checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL single_gnt_gap got=%b exp=00", bus.gnt); end
        checks++; if (bus.count !== 8'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", bus.count); end
        tick();
        checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL single_gnt2 got=%b exp=01", bus.gnt); end
        bus.req = 2'b00;
        tick();
        checks++; if (bus.count !== 8'd2) begin failures++; $display("FAIL single_count2 got=%0d exp=2", bus.count); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_seq [8];
        exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        do_reset();
        bus.req = 2'b11; bus.op0 = 2'b01; bus.op1 = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.gnt !== exp_seq[i]) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, bus.gnt, exp_seq[i]); end
        end
        bus.req = 2'b00;
        checks++; if (bus.count !== 8'd4) begin failures++; $display("FAIL rr_count got=%0d exp=4", bus.count); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rr_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_saturate();
        do_reset();
        bus.req = 2'b01; bus.op0 = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 16) begin
                checks++; if (bus.at_max !== 1'b0) begin failures++; $display("FAIL sat_at_max8 got=%b exp=0", bus.at_max); end
            end
            if (i == 18) begin
                checks++; if (bus.count !== 8'd9) begin failures++; $display("FAIL sat_count9 got=%0d exp=9", bus.count); end
                checks++; if (bus.at_max !== 1'b1) begin failures++; $display("FAIL sat_at_max9 got=%b exp=1", bus.at_max); end
                checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL sat_err9 got=%b exp=0", bus.err); end
            end
        end
        bus.req = 2'b00;
        checks++; if (bus.count !== 8'd9) begin failures++; $display("FAIL sat_count10 got=%0d exp=9", bus.count); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL sat_err10 got=%b exp=1", bus.err); end
    endtask

    task automatic test_dec_zero_clr();
        do_reset();
        bus.req = 2'b01; bus.op0 = 2'b10;
        tick();
        bus.req = 2'b00;
        tick();
        checks++; if (bus.count !== 8'd0) begin failures++; $display("FAIL dec0_count got=%0d exp=0", bus.count); end
        checks++; if (bus.at_zero !== 1'b1) begin failures++; $display("FAIL dec0_at_zero got=%b exp=1", bus.at_zero); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL dec0_err got=%b exp=1", bus.err); end
        bus.req = 2'b01; bus.op0 = 2'b11;
        tick();
        bus.req = 2'b00;
        tick();
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL clr_err_sticky got=%b exp=1", bus.err); end
    endtask

    task automatic test_tie_rr();
        do_reset();
        bus.req = 2'b01; bus.op0 = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (bus.count !== 8'd5) begin failures++; $display("FAIL tie_setup_count got=%0d exp=5", bus.count); end
        bus.req = 2'b11; bus.op0 = 2'b01; bus.op1 = 2'b11;
        tick();
        checks++; if (bus.gnt !== 2'b10) begin failures++; $display("FAIL tie_first_gnt got=%b exp=10", bus.gnt); end
        bus.req = 2'b01;
        bus.op1 = 2'b01;
        tick();
        checks++; if (bus.count !== 8'd0) begin failures++; $display("FAIL tie_clr_count got=%0d exp=0", bus.count); end
        tick();
        checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL tie_second_gnt got=%b exp=01", bus.gnt); end
        bus.req = 2'b00;
        tick();
        checks++; if (bus.count !== 8'd1) begin failures++; $display("FAIL tie_inc_count got=%0d exp=1", bus.count); end
    endtask

    task automatic test_rst_exec();
        do_reset();
        bus.req = 2'b01; bus.op0 = 2'b01;
        tick();
        checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL rstx_pre_gnt got=%b exp=01", bus.gnt); end
        rst = 1'b1;
        tick();
        checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL rstx_gnt got=%b exp=00", bus.gnt); end
        checks++; if (bus.count !== 8'd0) begin failures++; $display("FAIL rstx_count got=%0d exp=0", bus.count); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rstx_err got=%b exp=0", bus.err); end
        rst = 1'b0; bus.req = 2'b00;
        tick();
        checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL rstx_idle_gnt got=%b exp=00", bus.gnt); end
        bus.req = 2'b01;
        tick();
        checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL rstx_regrant got=%b exp=01", bus.gnt); end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_random();
        logic [1:0] rq;
        rq = 2'b00;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            rst = (($urandom % 97) == 0);
            if (rst) rq = 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (bus.gnt[i]) rq[i] = $urandom_range(0, 1) == 1;
                else if (!rq[i]) rq[i] = ($urandom % 3) == 0;
            end
            bus.req = rq;
            bus.op0 = rand_op();
            bus.op1 = rand_op();
            tick();
            checks++; if (bus.gnt !== m_gnt) begin failures++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", n, bus.gnt, m_gnt); end
            checks++; if (bus.count !== 8'(m_count)) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", n, bus.count, m_count); end
            checks++; if (bus.at_max !== (m_count == LIMIT)) begin failures++; $display("FAIL rand_at_max cyc=%0d got=%b exp=%b", n, bus.at_max, m_count == LIMIT); end
            checks++; if (bus.at_zero !== (m_count == 0)) begin failures++; $display("FAIL rand_at_zero cyc=%0d got=%b exp=%b", n, bus.at_zero, m_count == 0); end
            checks++; if (bus.err !== m_err) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", n, bus.err, m_err); end
        end
        rst = 1'b0;
        bus.req = 2'b00;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req  = 2'b00;
        bus.op0  = 2'b00;
        bus.op1  = 2'b00;
        test_reset();
        test_single_inc();
        test_round_robin();
        test_saturate();
        test_dec_zero_clr();
        test_tie_rr();
        test_rst_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
